// File: rtl/next_frame_writer_if.sv
// Pixel-request handshake plus SRAM bus for the next-frame writer.
// The slave modport is the writer itself; the master modport is the producer/SRAM side.
interface next_frame_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x;
  logic [9:0]  req_y;
  logic [3:0]  req_color;
  logic [19:0] SRAM_ADDRESS;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;

  modport master (
    output req_valid, req_x, req_y, req_color, Data_from_SRAM,
    input  req_ready, SRAM_ADDRESS, Data_to_SRAM, SRAM_OE_N, SRAM_WE_N
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color, Data_from_SRAM,
    output req_ready, SRAM_ADDRESS, Data_to_SRAM, SRAM_OE_N, SRAM_WE_N
  );
endinterface

// File: rtl/next_frame_writer.sv
// Draws into the next frame buffer of a double-buffered SRAM frame store:
// single-pixel read-modify-write of 4-pixel words, and a bulk clear to a background colour.
module next_frame_writer #(
  parameter int H_WORDS = 160,
  parameter int V_ROWS  = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       EN,
  input  logic       even_frame,
  input  logic       clear_start,
  input  logic [3:0] clear_color,
  output logic       busy,
  next_frame_writer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, CLR} state_t;

  localparam logic [7:0] LAST_COL = 8'(H_WORDS - 1);
  localparam logic [9:0] LAST_ROW = 10'(V_ROWS - 1);
  localparam logic [9:0] X_LIMIT  = 10'(H_WORDS * 4);
  localparam logic [9:0] Y_LIMIT  = 10'(V_ROWS);

  state_t      state;
  state_t      next_state;
  logic        buf_sel;
  logic [9:0]  row;
  logic [7:0]  col;
  logic [1:0]  nib;
  logic [3:0]  pix_color;
  logic [3:0]  clr_color;
  logic [15:0] rd_data;
  logic [15:0] merged;
  logic        ready;
  logic        in_range;
  logic        accept;
  logic        clear_go;
  logic        clear_last;

  assign in_range   = (bus.req_x < X_LIMIT) && (bus.req_y < Y_LIMIT);
  assign ready      = EN && !Reset && (state == IDLE) && !clear_start;
  assign accept     = ready && bus.req_valid;
  assign clear_go   = EN && (state == IDLE) && clear_start;
  assign clear_last = (col == LAST_COL) && (row == LAST_ROW);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // EN low freezes everything, except that an interrupted read wait falls back to RD
  // so the SRAM read is always re-issued before a write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (clear_go)                 next_state = CLR;
        else if (accept && in_range)  next_state = RD;
      end
      RD:      if (EN) next_state = RD_WAIT;
      RD_WAIT: next_state = EN ? WR : RD;
      WR:      if (EN) next_state = IDLE;
      CLR:     if (EN && clear_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      buf_sel   <= 1'b0;
      row       <= '0;
      col       <= '0;
      nib       <= '0;
      pix_color <= '0;
      clr_color <= '0;
      rd_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_go) begin
            buf_sel   <= ~even_frame;
            clr_color <= clear_color;
            row       <= '0;
            col       <= '0;
          end else if (accept && in_range) begin
            buf_sel   <= ~even_frame;
            row       <= bus.req_y;
            col       <= bus.req_x[9:2];
            nib       <= bus.req_x[1:0];
            pix_color <= bus.req_color;
          end
        end
        RD_WAIT: if (EN) rd_data <= bus.Data_from_SRAM;
        CLR: begin
          if (EN) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (row != LAST_ROW) row <= row + 10'd1;
            end else begin
              col <= col + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    merged = rd_data;
    merged[{nib, 2'b00} +: 4] = pix_color;
  end

  always_comb begin
    bus.req_ready    = ready;
    busy             = (state != IDLE);
    bus.SRAM_ADDRESS = {1'b0, buf_sel, row, col};
    bus.SRAM_OE_N    = 1'b1;
    bus.SRAM_WE_N    = 1'b1;
    bus.Data_to_SRAM = '0;
    if (EN) begin
      case (state)
        RD, RD_WAIT: bus.SRAM_OE_N = 1'b0;
        WR: begin
          bus.SRAM_WE_N    = 1'b0;
          bus.Data_to_SRAM = merged;
        end
        CLR: begin
          bus.SRAM_WE_N    = 1'b0;
          bus.Data_to_SRAM = {4{clr_color}};
        end
        default: ;
      endcase
    end
  end

endmodule
